// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch control in front of a registered-read
// instruction memory. Presents each fetched word with its PC to decode over a
// valid/ready handshake, parks the word in a one-entry hold buffer while decode
// stalls, and squashes the in-flight fetch on a branch/jump redirect.
module fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clock,
   input  logic        reset,
   output logic [7:0]  instructionAdress,
   input  logic [31:0] instructionIn,
   input  logic        branchTaken,
   input  logic [7:0]  branchTarget,
   input  logic        ifidReady,
   output logic        ifidValid,
   output logic [31:0] ifidInstruction,
   output logic [7:0]  ifidPc,
   output logic [7:0]  ifidPcPlus4,
   output logic [15:0] fetchedCount
);

   // Fetch state is not stored separately; it is decoded from the two flags.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LIVE  = 2'd1,
      ST_HELD  = 2'd2
   } fetch_state_t;

   logic [7:0]   pc;
   logic [7:0]   req_pc;
   logic         req_valid;
   logic [31:0]  hold_instr;
   logic         hold_active;
   logic [15:0]  fetch_count;

   logic [7:0]   pc_next;
   logic [7:0]   req_pc_next;
   logic         req_valid_next;
   logic [31:0]  hold_instr_next;
   logic         hold_active_next;
   logic [15:0]  fetch_count_next;

   fetch_state_t state;
   logic         accept;

   // Redirect targets are word aligned; the low two bits are dropped.
   function automatic logic [7:0] align_word(input logic [7:0] addr);
      return addr & 8'hFC;
   endfunction

   // Accepted-word counter sticks at its maximum instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] count);
      return (count == 16'hFFFF) ? count : count + 16'd1;
   endfunction

   // Decode the current fetch state from the valid and hold flags.
   always_comb begin
      if (!req_valid)
         state = ST_EMPTY;
      else if (hold_active)
         state = ST_HELD;
      else
         state = ST_LIVE;
   end

   assign accept = req_valid & ifidReady;

   // State register: all fetch bookkeeping, cleared asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         req_pc      <= RESET_PC;
         req_valid   <= 1'b0;
         hold_instr  <= 32'd0;
         hold_active <= 1'b0;
         fetch_count <= 16'd0;
      end else begin
         pc          <= pc_next;
         req_pc      <= req_pc_next;
         req_valid   <= req_valid_next;
         hold_instr  <= hold_instr_next;
         hold_active <= hold_active_next;
         fetch_count <= fetch_count_next;
      end
   end

   // Next-state logic: redirect beats stall, stall beats advance.
   always_comb begin
      pc_next          = pc;
      req_pc_next      = req_pc;
      req_valid_next   = req_valid;
      hold_instr_next  = hold_instr;
      hold_active_next = hold_active;
      fetch_count_next = fetch_count;

      if (branchTaken) begin
         // The word the memory returns next belongs to the old path, so the
         // next cycle is a bubble while mem[target] is being read.
         pc_next          = align_word(branchTarget);
         req_valid_next   = 1'b0;
         hold_active_next = 1'b0;
      end else begin
         case (state)
            ST_LIVE: begin
               if (!ifidReady) begin
                  // Memory moves on to mem[pc] next edge; capture the word now.
                  hold_instr_next  = instructionIn;
                  hold_active_next = 1'b1;
               end else begin
                  req_pc_next = pc;
                  pc_next     = pc + 8'd4;
               end
            end
            ST_HELD: begin
               if (ifidReady) begin
                  // instructionIn already holds mem[pc], so no word is lost.
                  req_pc_next      = pc;
                  pc_next          = pc + 8'd4;
                  hold_active_next = 1'b0;
               end
            end
            default: begin
               req_pc_next      = pc;
               req_valid_next   = 1'b1;
               pc_next          = pc + 8'd4;
               hold_active_next = 1'b0;
            end
         endcase

         if (accept)
            fetch_count_next = sat_inc(fetch_count);
      end
   end

   // Output logic: memory address and decode-side view of the fetched word.
   always_comb begin
      instructionAdress = pc;
      ifidValid         = req_valid;
      ifidPc            = req_pc;
      ifidPcPlus4       = req_pc + 8'd4;
      ifidInstruction   = hold_active ? hold_instr : instructionIn;
      fetchedCount      = fetch_count;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit against a registered-read memory model,
// checks per-cycle vectors from a table and hand sequences, and compares every
// accepted word against a queue of expected (pc, word) pairs.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic [7:0]  instructionAdress;
   logic [31:0] instructionIn;
   logic        branchTaken;
   logic [7:0]  branchTarget;
   logic        ifidReady;
   logic        ifidValid;
   logic [31:0] ifidInstruction;
   logic [7:0]  ifidPc;
   logic [7:0]  ifidPcPlus4;
   logic [15:0] fetchedCount;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        ready;
      logic        br;
      logic [7:0]  target;
      logic        exp_valid;
      logic [7:0]  exp_pc;
      logic [7:0]  exp_addr;
      logic [15:0] exp_cnt;
   } vec_t;

   typedef struct packed {
      logic [7:0]  pc;
      logic [31:0] instr;
   } sb_t;

   vec_t  vecs[11];
   sb_t   sb[$];
   logic [31:0] mem [64];

   fetch_unit #(.RESET_PC(8'h00)) dut (
      .clock(clock),
      .reset(reset),
      .instructionAdress(instructionAdress),
      .instructionIn(instructionIn),
      .branchTaken(branchTaken),
      .branchTarget(branchTarget),
      .ifidReady(ifidReady),
      .ifidValid(ifidValid),
      .ifidInstruction(ifidInstruction),
      .ifidPc(ifidPc),
      .ifidPcPlus4(ifidPcPlus4),
      .fetchedCount(fetchedCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memory with a one-cycle registered read.
   always @(posedge clock) instructionIn <= mem[instructionAdress[7:2]];

   function automatic logic [31:0] memword(input logic [7:0] a);
      return {8'hA5, a, ~a, 8'h3C};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] pc);
      sb.push_back('{pc: pc, instr: memword(pc)});
   endtask

   task automatic apply(input logic r, input logic b, input logic [7:0] t);
      ifidReady    = r;
      branchTaken  = b;
      branchTarget = t;
      #1;
   endtask

   // Scoreboard pop on an accept, then advance to the next falling edge.
   task automatic cycle_end();
      sb_t e;
      if (ifidValid && ifidReady && !branchTaken) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_accept: got pc %h expected no accept", ifidPc);
         end else begin
            e = sb.pop_front();
            chk("sb_pc", {24'd0, ifidPc}, {24'd0, e.pc});
            chk("sb_instr", ifidInstruction, e.instr);
         end
      end
      @(negedge clock);
   endtask

   initial begin
      for (int k = 0; k < 64; k++) mem[k] = memword(8'(k * 4));

      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 16'd0};
      vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h04, 16'd0};
      vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h08, 16'd1};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h08, 8'h0C, 16'd2};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h08, 8'h0C, 16'd2};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h08, 8'h0C, 16'd2};
      vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 8'h0C, 16'd2};
      vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h0C, 8'h10, 16'd3};
      vecs[8]  = '{1'b1, 1'b1, 8'h2D, 1'b1, 8'h10, 8'h14, 16'd4};
      vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 8'h2C, 16'd4};
      vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h2C, 8'h30, 16'd4};

      reset = 1'b1;
      ifidReady = 1'b0;
      branchTaken = 1'b0;
      branchTarget = 8'h00;
      @(negedge clock);
      @(negedge clock);
      chk("rst_valid", {31'd0, ifidValid}, 32'd0);
      chk("rst_addr", {24'd0, instructionAdress}, 32'h00);
      chk("rst_pc", {24'd0, ifidPc}, 32'h00);
      chk("rst_pc4", {24'd0, ifidPcPlus4}, 32'h04);
      chk("rst_cnt", {16'd0, fetchedCount}, 32'd0);
      reset = 1'b0;

      // Table: sequential fetch, 3-cycle stall at pc 08, redirect to 2D.
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].ready && !vecs[i].br && vecs[i].exp_valid) push(vecs[i].exp_pc);
         apply(vecs[i].ready, vecs[i].br, vecs[i].target);
         chk($sformatf("v%0d_valid", i), {31'd0, ifidValid}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("v%0d_addr", i), {24'd0, instructionAdress}, {24'd0, vecs[i].exp_addr});
         chk($sformatf("v%0d_pc", i), {24'd0, ifidPc}, {24'd0, vecs[i].exp_pc});
         chk($sformatf("v%0d_pc4", i), {24'd0, ifidPcPlus4}, {24'd0, vecs[i].exp_pc + 8'd4});
         chk($sformatf("v%0d_cnt", i), {16'd0, fetchedCount}, {16'd0, vecs[i].exp_cnt});
         if (vecs[i].exp_valid)
            chk($sformatf("v%0d_instr", i), ifidInstruction, memword(vecs[i].exp_pc));
         cycle_end();
      end

      // Redirect while HELD: hold dropped, one bubble, count unchanged.
      apply(1'b0, 1'b0, 8'h00);
      chk("hs_pc_live", {24'd0, ifidPc}, 32'h30);
      cycle_end();
      apply(1'b0, 1'b0, 8'h00);
      chk("hs_pc_held", {24'd0, ifidPc}, 32'h30);
      chk("hs_instr_held", ifidInstruction, memword(8'h30));
      cycle_end();
      apply(1'b0, 1'b1, 8'h40);
      chk("hs_cnt_pre", {16'd0, fetchedCount}, 32'd5);
      cycle_end();
      apply(1'b1, 1'b0, 8'h00);
      chk("hs_bubble", {31'd0, ifidValid}, 32'd0);
      chk("hs_addr", {24'd0, instructionAdress}, 32'h40);
      chk("hs_cnt_post", {16'd0, fetchedCount}, 32'd5);
      cycle_end();
      push(8'h40);
      apply(1'b1, 1'b0, 8'h00);
      chk("hs_valid40", {31'd0, ifidValid}, 32'd1);
      chk("hs_pc40", {24'd0, ifidPc}, 32'h40);
      cycle_end();

      // Wrap across the top of the 8-bit address space.
      apply(1'b1, 1'b1, 8'hF8);
      cycle_end();
      apply(1'b1, 1'b0, 8'h00);
      chk("wr_bubble", {31'd0, ifidValid}, 32'd0);
      chk("wr_addr", {24'd0, instructionAdress}, 32'hF8);
      cycle_end();
      for (int i = 0; i < 4; i++) begin
         logic [7:0] p;
         p = 8'hF8 + 8'(i * 4);
         push(p);
         apply(1'b1, 1'b0, 8'h00);
         chk($sformatf("wr%0d_valid", i), {31'd0, ifidValid}, 32'd1);
         chk($sformatf("wr%0d_pc", i), {24'd0, ifidPc}, {24'd0, p});
         chk($sformatf("wr%0d_pc4", i), {24'd0, ifidPcPlus4}, {24'd0, p + 8'd4});
         cycle_end();
      end
      chk("wr_cnt", {16'd0, fetchedCount}, 32'd10);

      // Back-to-back redirects: last one wins, single bubble after it.
      apply(1'b1, 1'b1, 8'h20);
      cycle_end();
      apply(1'b1, 1'b1, 8'h83);
      chk("bb_valid_mid", {31'd0, ifidValid}, 32'd0);
      chk("bb_addr_mid", {24'd0, instructionAdress}, 32'h20);
      cycle_end();
      apply(1'b0, 1'b0, 8'h00);
      chk("bb_valid_bubble", {31'd0, ifidValid}, 32'd0);
      chk("bb_addr", {24'd0, instructionAdress}, 32'h80);
      cycle_end();
      apply(1'b0, 1'b0, 8'h00);
      chk("bb_pc80", {24'd0, ifidPc}, 32'h80);
      chk("bb_instr80", ifidInstruction, memword(8'h80));
      cycle_end();
      apply(1'b0, 1'b0, 8'h00);
      chk("bb_held80", ifidInstruction, memword(8'h80));

      // Asynchronous reset between edges while HELD.
      #2;
      reset = 1'b1;
      #1;
      chk("ar_valid", {31'd0, ifidValid}, 32'd0);
      chk("ar_addr", {24'd0, instructionAdress}, 32'h00);
      chk("ar_pc", {24'd0, ifidPc}, 32'h00);
      chk("ar_pc4", {24'd0, ifidPcPlus4}, 32'h04);
      chk("ar_cnt", {16'd0, fetchedCount}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      apply(1'b1, 1'b0, 8'h00);
      chk("ar_first_bubble", {31'd0, ifidValid}, 32'd0);
      cycle_end();
      push(8'h00);
      push(8'h04);
      apply(1'b1, 1'b0, 8'h00);
      chk("ar_pc00", {24'd0, ifidPc}, 32'h00);
      cycle_end();
      apply(1'b1, 1'b0, 8'h00);
      chk("ar_pc04", {24'd0, ifidPc}, 32'h04);
      chk("ar_cnt1", {16'd0, fetchedCount}, 32'd1);
      cycle_end();

      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-control stage sitting directly upstream of the instruction memory. It drives the memory's 8-bit byte address and tracks which address the memory's one-cycle registered read belongs to. It presents the returned 32-bit word plus its PC to the decode stage over a valid/ready handshake. It also absorbs decode stalls with a one-entry hold buffer and squashes in-flight fetches on branch/jump redirect.

## Interface
Parameters:
- RESET_PC, 8'h00, byte address fetched first after reset; bits [1:0] must be 0.

Ports:
- clock  in  1  rising-edge clock, shared with instruction memory
- reset  in  1  asynchronous, active-high
- instructionAdress  out  8  byte address to instruction memory; equals pc register
- instructionIn  in  32  instruction memory output; holds mem[address presented before the last edge]
- branchTaken  in  1  single-cycle redirect request from a later stage
- branchTarget  in  8  redirect byte address; bits [1:0] ignored and forced to 00
- ifidReady  in  1  decode stage accepts the current word this cycle
- ifidValid  out  1  ifidInstruction/ifidPc hold a valid fetched word
- ifidInstruction  out  32  fetched instruction
- ifidPc  out  8  byte address of ifidInstruction
- ifidPcPlus4  out  8  ifidPc + 4, modulo 256
- fetchedCount  out  16  number of accepted words, saturates at 16'hFFFF

## Operation
- Registers: pc[7:0], reqPc[7:0], reqValid, holdInstr[31:0], holdActive, fetchedCount.
- Combinational outputs:
  - instructionAdress = pc
  - ifidValid = reqValid
  - ifidPc = reqPc
  - ifidPcPlus4 = reqPc + 8'd4
  - ifidInstruction = holdActive ? holdInstr : instructionIn
- States, derived from the flags:
  - EMPTY: reqValid=0
  - LIVE: reqValid=1, holdActive=0
  - HELD: reqValid=1, holdActive=1
- Each rising edge, evaluated in priority order:
  1. branchTaken=1 (any state): pc <= {branchTarget[7:2],2'b00}; reqValid <= 0; holdActive <= 0; next state EMPTY. Redirect beats stall.
  2. reqValid=1 and ifidReady=0 (stall): pc, reqPc, reqValid hold. In LIVE: holdInstr <= instructionIn, holdActive <= 1, go to HELD. In HELD: nothing changes.
  3. Otherwise (EMPTY, or accept = reqValid & ifidReady): reqPc <= pc; reqValid <= 1; pc <= pc + 4; holdActive <= 0; next state LIVE.
- fetchedCount increments on every accept edge with branchTaken=0, and saturates.
- Stall correctness: while stalled, the memory keeps reading pc (= reqPc+4). On release, reqPc <= pc and instructionIn already equals mem[pc], so no word is lost or duplicated.
- pc arithmetic is 8-bit: 8'hFC + 4 wraps to 8'h00. No error is flagged.

## Timing
- Reset values: pc=RESET_PC, reqPc=RESET_PC, reqValid=0, holdActive=0, holdInstr=0, fetchedCount=0.
  - Therefore instructionAdress=RESET_PC, ifidValid=0, ifidPc=RESET_PC, ifidPcPlus4=RESET_PC+4, fetchedCount=0.
- Reset mid-operation clears everything immediately (asynchronous); any in-flight or held word is discarded.
- Fetch latency: an address is driven in cycle n, and the word is valid with ifidValid=1 in cycle n+1.
- Throughput: one word per cycle while ifidReady=1 and no redirect.
- Redirect penalty: the redirect edge is followed by exactly one EMPTY cycle (ifidValid=0). mem[target] is valid in the next cycle.
- First word after reset release: ifidValid=0 in the first cycle, then mem[RESET_PC] appears in the second cycle.
- Handshake:
  - ifidValid never drops without an accept or a redirect.
  - ifidInstruction and ifidPc are stable while ifidValid=1 and ifidReady=0.
  - ifidReady is ignored when ifidValid=0.
- branchTaken asserted in EMPTY still retargets pc.
- Back-to-back branchTaken pulses: the last one wins, and ifidValid stays 0 until one cycle after the final pulse.

## Test plan
- Reset then ifidReady=1 constant, memory preloaded with word k at address 4k → ifidValid=0 for 1 cycle, then ifidPc=0,4,8,12 with matching words; fetchedCount=4 after 4 accepts.
- Stall: drop ifidReady for 3 cycles while ifidPc=8 → ifidPc=8 and ifidInstruction=mem[8] held all 3 cycles; after release next ifidPc=12 with mem[12], no gaps or repeats.
- Redirect: branchTaken=1, branchTarget=8'h2D while ifidPc=16 → next cycle ifidValid=0; following cycle ifidPc=8'h2C with mem[8'h2C].
- Redirect during stall: ifidReady=0 in HELD and branchTaken=1, target 8'h40 → hold cleared, one bubble, then ifidPc=8'h40; fetchedCount unchanged.
- Wrap: redirect to 8'hF8, ready=1 → ifidPc sequence F8, FC, 00, 04; ifidPcPlus4 at FC equals 00.
- Asynchronous reset asserted mid-stall, between clock edges → outputs return to reset values immediately (ifidValid=0, instructionAdress=RESET_PC); after release fetch restarts at RESET_PC.
